// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the cascaded modulo counter.
// digit_t is the default-width digit; clamp_mod gives the effective modulus.
// MOD_MIN is the smallest modulus a digit can run with.
package mod_counter_pkg;

    localparam int unsigned DIGIT_W_DEF = 4;
    localparam int unsigned MOD_MIN     = 2;

    typedef logic [DIGIT_W_DEF-1:0] digit_t;

    // Effective modulus: mod_val clamped to MOD_MIN .. 2^digit_w.
    function automatic int unsigned clamp_mod(input int unsigned mod_val,
                                              input int unsigned digit_w);
        int unsigned mod_max;
        mod_max = 32'd1 << digit_w;
        if (mod_val < MOD_MIN) begin
            clamp_mod = MOD_MIN;
        end else if (mod_val > mod_max) begin
            clamp_mod = mod_max;
        end else begin
            clamp_mod = mod_val;
        end
    endfunction

endpackage

// File: rtl/mod_digit.sv
// One modulo-m up/down digit with saturating load; step_out chains to the next digit.
// Ports: clk/rst (async high), clr/load/load_val, step_in/dir/m in; value, step_out out.
// Latency: value updates one edge after step_in/clr/load; step_out is combinational.
module mod_digit
    import mod_counter_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               step_in,
    input  logic               dir,
    input  logic [DIGIT_W:0]   m,
    output logic [DIGIT_W-1:0] value,
    output logic               step_out
);

    localparam logic [DIGIT_W-1:0] D_ONE = DIGIT_W'(1);
    localparam logic [DIGIT_W:0]   M_ONE = (DIGIT_W+1)'(1);

    logic [DIGIT_W:0]   m_dec;      // m-1 at full width
    logic [DIGIT_W-1:0] m_max;      // m-1 as a digit value (m <= 2^DIGIT_W so it fits)
    logic [DIGIT_W:0]   value_ext;
    logic [DIGIT_W-1:0] load_sat;
    logic [DIGIT_W-1:0] next_val;
    logic               wrap;

    assign m_dec     = m - M_ONE;
    assign m_max     = m_dec[DIGIT_W-1:0];
    assign value_ext = {1'b0, value};

    // A load digit at or above the modulus saturates to the top value.
    assign load_sat = ({1'b0, load_val} >= m) ? m_max : load_val;

    always_comb begin
        next_val = value;
        wrap     = 1'b0;
        if (dir) begin
            // Out-of-range values (after a modulus drop) also wrap to 0 with carry.
            if (value_ext >= m_dec) begin
                next_val = '0;
                wrap     = 1'b1;
            end else begin
                next_val = value + D_ONE;
            end
        end else begin
            if (value == '0) begin
                next_val = m_max;
                wrap     = 1'b1;
            end else if (value_ext > m_dec) begin
                // Out of range going down: snap to top without borrowing.
                next_val = m_max;
            end else begin
                next_val = value - D_ONE;
            end
        end
    end

    assign step_out = step_in & wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (load) begin
            value <= load_sat;
        end else if (step_in) begin
            value <= next_val;
        end
    end

endmodule

// File: rtl/mod_counter_multi.sv
// N-digit cascaded modulo up/down counter with prescaler, clear, saturating load.
// Ports: sys_clk_in/sys_rst (async high); en, dir, mod_val, clr, load, load_data in;
//        count, tc (terminal count), carry_out (wrap pulse), ovf (sticky wrap) out.
module mod_counter_multi
    import mod_counter_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DIGIT_W  = 4,
    parameter int PRESCALE = 1
) (
    input  logic                      sys_clk_in,
    input  logic                      sys_rst,
    input  logic                      en,
    input  logic                      dir,
    input  logic [DIGIT_W:0]          mod_val,
    input  logic                      clr,
    input  logic                      load,
    input  logic [DIGITS*DIGIT_W-1:0] load_data,
    output logic [DIGITS*DIGIT_W-1:0] count,
    output logic                      tc,
    output logic                      carry_out,
    output logic                      ovf
);

    localparam logic [DIGIT_W:0] M_ONE = (DIGIT_W+1)'(1);

    logic [DIGIT_W:0] m;
    logic             step;
    logic [DIGITS:0]  step_chain;
    logic             wrap;

    assign m = (DIGIT_W+1)'(clamp_mod(32'(mod_val), DIGIT_W));

    // Prescaler: step fires on the PRESCALE-th enabled cycle.
    generate
        if (PRESCALE > 1) begin : g_presc
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
            localparam logic [PW-1:0] P_ONE  = PW'(1);
            logic [PW-1:0] presc;

            assign step = en && (presc == P_LAST);

            always_ff @(posedge sys_clk_in or posedge sys_rst) begin
                if (sys_rst) begin
                    presc <= '0;
                end else if (clr || load) begin
                    presc <= '0;
                end else if (en) begin
                    presc <= (presc == P_LAST) ? '0 : presc + P_ONE;
                end
            end
        end else begin : g_nopresc
            assign step = en;
        end
    endgenerate

    assign step_chain[0] = step;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            mod_digit #(
                .DIGIT_W (DIGIT_W)
            ) u_digit (
                .clk      (sys_clk_in),
                .rst      (sys_rst),
                .clr      (clr),
                .load     (load),
                .load_val (load_data[i*DIGIT_W +: DIGIT_W]),
                .step_in  (step_chain[i]),
                .dir      (dir),
                .m        (m),
                .value    (count[i*DIGIT_W +: DIGIT_W]),
                .step_out (step_chain[i+1])
            );
        end
    endgenerate

    // Carry/borrow out of the top digit is a whole-counter wrap.
    assign wrap = step_chain[DIGITS];

    always_ff @(posedge sys_clk_in or posedge sys_rst) begin
        if (sys_rst) begin
            carry_out <= 1'b0;
            ovf       <= 1'b0;
        end else if (clr || load) begin
            carry_out <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            carry_out <= wrap;
            if (wrap) begin
                ovf <= 1'b1;
            end
        end
    end

    // Terminal count: all digits at m-1 going up, all zero going down.
    always_comb begin
        logic tc_up;
        logic tc_dn;
        tc_up = 1'b1;
        tc_dn = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ({1'b0, count[i*DIGIT_W +: DIGIT_W]} != (m - M_ONE)) begin
                tc_up = 1'b0;
            end
            if (count[i*DIGIT_W +: DIGIT_W] != '0) begin
                tc_dn = 1'b0;
            end
        end
        tc = dir ? tc_up : tc_dn;
    end

endmodule
